// File: rtl/pipeline_hazard_controller_pkg.sv
// Opcode constants, FSM state encodings and decode helpers shared with the
// decode/forwarding stage.
package pipeline_hazard_controller_pkg;

   localparam logic [5:0] OP_LD      = 6'b010100;
   localparam logic [5:0] OP_JMP     = 6'b011000;
   localparam logic [3:0] OP_CJ_PFX  = 4'b0111;
   localparam logic [2:0] OP_IMM_PFX = 3'b001;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_FLUSH   = 2'b01,
      ST_BR_WAIT = 2'b10,
      ST_RSVD    = 2'b11
   } state_e;

   function automatic logic op_is_cj(input logic [5:0] op);
      return op[5:2] == OP_CJ_PFX;
   endfunction

   // Immediate forms and both jump kinds carry no register source in rb.
   function automatic logic op_reads_rb(input logic [5:0] op);
      return !(op[5:3] == OP_IMM_PFX || op == OP_JMP || op_is_cj(op));
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module pipeline_hazard_controller_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Decode-stage sequencer: load-use stalls, jump squashing, conditional-jump
// wait with timeout, and saturating stall/flush statistics.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int BR_TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      ins,
   input  logic             ins_valid,
   input  logic             br_valid,
   input  logic             br_taken,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             br_err
);

   localparam int TMR_W = $clog2(BR_TIMEOUT + 1);

   state_e           state_q, state_d;
   logic             ex_ld_q, ex_ld_d;
   logic [4:0]       ex_rd_q, ex_rd_d;
   logic [TMR_W-1:0] br_tmr_q, br_tmr_d;
   logic             br_err_q, br_err_d;

   logic [5:0] op;
   logic [4:0] rd, ra, rb;
   logic       hazard;
   logic       issue;
   logic       unused_ins_bits;

   assign unused_ins_bits = ^ins[10:0];

   always_comb begin
      op     = ins[31:26];
      rd     = ins[25:21];
      ra     = ins[20:16];
      rb     = ins[15:11];
      hazard = (state_q == ST_RUN) && ins_valid && ex_ld_q && (ex_rd_q != 5'd0) &&
               ((ex_rd_q == ra) || ((ex_rd_q == rb) && op_reads_rb(op)));
      issue  = (state_q == ST_RUN) && ins_valid && !hazard;
   end

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            pc_en       = !hazard;
            ifid_en     = !hazard;
            idex_bubble = hazard;
         end
         ST_FLUSH: begin
            ifid_flush  = 1'b1;
         end
         ST_BR_WAIT: begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
         end
         default: begin
         end
      endcase
   end

   // Next-state, load tracking (cleared whenever nothing issues) and branch timer.
   always_comb begin
      state_d  = state_q;
      br_err_d = br_err_q;
      br_tmr_d = '0;
      ex_ld_d  = issue && (op == OP_LD);
      ex_rd_d  = issue ? rd : 5'd0;
      unique case (state_q)
         ST_RUN: begin
            if (issue && (op == OP_JMP)) begin
               state_d = ST_FLUSH;
            end else if (issue && op_is_cj(op)) begin
               state_d = ST_BR_WAIT;
            end
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         ST_BR_WAIT: begin
            if (br_valid) begin
               state_d = br_taken ? ST_FLUSH : ST_RUN;
            end else if (br_tmr_q == TMR_W'(BR_TIMEOUT - 1)) begin
               state_d  = ST_RUN;
               br_err_d = 1'b1;
            end else begin
               br_tmr_d = br_tmr_q + TMR_W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         ex_ld_q  <= 1'b0;
         ex_rd_q  <= 5'd0;
         br_tmr_q <= '0;
         br_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ex_ld_q  <= ex_ld_d;
         ex_rd_q  <= ex_rd_d;
         br_tmr_q <= br_tmr_d;
         br_err_q <= br_err_d;
      end
   end

   assign state  = state_q;
   assign br_err = br_err_q;

   pipeline_hazard_controller_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!pc_en),
      .cnt   (stall_cnt)
   );

   pipeline_hazard_controller_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ifid_flush),
      .cnt   (flush_cnt)
   );

endmodule
